// File: rtl/frame_tick_monitor.sv
// Frame-clock receiver: synchronizes frame_clk, emits a tick per rising edge, measures
// the period, tracks lock and flags early/late edges. Optional macro: FRAME_MON_STATS_EN.
module frame_tick_monitor #(
  parameter int unsigned EXP_PERIOD  = 6252,
  parameter int unsigned TOL         = 16,
  parameter int unsigned LOCK_N      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        frame_clk,
  input  logic        err_clr,
  output logic        tick,
  output logic        locked,
  output logic [15:0] period,
  output logic [15:0] frame_cnt,
  output logic        err_early,
  output logic        err_late,
  output logic [7:0]  err_cnt
);

  localparam logic [16:0] LO = 17'(EXP_PERIOD) - 17'(TOL);
  localparam logic [16:0] HI = 17'(EXP_PERIOD) + 17'(TOL);

  typedef enum logic [1:0] {ACQ, TRACK, LOCKED} state_t;

  state_t                 state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   s_d;
  logic                   rise;
  logic [15:0]            pcnt;
  logic [16:0]            pcnt_w;
  logic [3:0]             good_cnt, good_cnt_nx;
  logic                   good, early, timeout;
  logic                   set_early, set_late, upd_period;

  assign rise   = sync[SYNC_STAGES-1] & ~s_d;
  assign pcnt_w = {1'b0, pcnt};
  assign good   = (pcnt_w >= LO) && (pcnt_w <= HI);
  assign early  = pcnt_w < LO;
  // Fires on the cycle pcnt steps to HI+1, so err_late is visible alongside that count.
  assign timeout = (pcnt_w == HI) && !rise;

  always_comb begin
    state_nx    = state;
    good_cnt_nx = good_cnt;
    set_early   = 1'b0;
    set_late    = 1'b0;
    upd_period  = 1'b0;
    unique case (state)
      ACQ: begin
        if (rise) begin
          state_nx    = TRACK;
          good_cnt_nx = '0;
        end
      end
      TRACK, LOCKED: begin
        if (rise) begin
          upd_period = 1'b1;
          if (good) begin
            if (state == TRACK) begin
              good_cnt_nx = good_cnt + 4'd1;
              if (good_cnt + 4'd1 == 4'(LOCK_N)) state_nx = LOCKED;
            end
          end else begin
            set_early   = early;
            good_cnt_nx = '0;
            state_nx    = TRACK;
          end
        end else if (timeout) begin
          set_late = 1'b1;
          state_nx = ACQ;
        end
      end
      default: state_nx = ACQ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state     <= ACQ;
      sync      <= '0;
      s_d       <= 1'b0;
      pcnt      <= '0;
      good_cnt  <= '0;
      tick      <= 1'b0;
      locked    <= 1'b0;
      period    <= '0;
      frame_cnt <= '0;
      err_early <= 1'b0;
      err_late  <= 1'b0;
    end else begin
      state    <= state_nx;
      sync     <= {sync[SYNC_STAGES-2:0], frame_clk};
      s_d      <= sync[SYNC_STAGES-1];
      good_cnt <= good_cnt_nx;
      tick     <= rise;
      locked   <= (state_nx == LOCKED);
      if (rise)               pcnt <= 16'd1;
      else if (pcnt != '1)    pcnt <= pcnt + 16'd1;
      if (upd_period)         period <= pcnt;
      if (rise)               frame_cnt <= frame_cnt + 16'd1;
      if (set_early)          err_early <= 1'b1;
      else if (err_clr)       err_early <= 1'b0;
      if (set_late)           err_late <= 1'b1;
      else if (err_clr)       err_late <= 1'b0;
    end
  end

`ifdef FRAME_MON_STATS_EN
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset)                                     err_cnt <= '0;
    else if ((set_early || set_late) && err_cnt != '1) err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = '0;
`endif

endmodule
